// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I core types plus branch-resolution additions
package rv32i_types;
  typedef logic [31:0] rv32i_word;
  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;
  typedef logic [1:0] bht_cnt_t;
  localparam bht_cnt_t BHT_INIT = 2'b01;
  typedef enum logic {IDLE, REDIR} br_ctrl_state_t;
endpackage

// File: rtl/branch_resolve_ctrl_bht.sv
// bht: 2-bit saturating direction counters, async read, sync update
module bht
  import rv32i_types::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_cnt_t         rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  bht_cnt_t mem_q [2**IDX_W];
  bht_cnt_t cur, cnt_d;
  assign rd_cnt = mem_q[rd_idx];
  assign cur = mem_q[wr_idx];
  always_comb begin
    cnt_d = wr_taken ? (cur == 2'b11 ? cur : cur + 2'd1) : (cur == 2'b00 ? cur : cur - 2'd1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**IDX_W; i++) mem_q[i] <= BHT_INIT;
    end else if (wr_en) begin
      mem_q[wr_idx] <= cnt_d;
    end
  end
endmodule

// File: rtl/cmp.sv
// cmp: RV32I branch comparator selected by funct3
module cmp
  import rv32i_types::*;
(
  input  rv32i_word      a,
  input  rv32i_word      b,
  input  branch_funct3_t funct3,
  output logic           out
);
  always_comb begin
    case (funct3)
      beq:     out = a == b;
      bne:     out = a != b;
      blt:     out = $signed(a) < $signed(b);
      bge:     out = $signed(a) >= $signed(b);
      bltu:    out = a < b;
      bgeu:    out = a >= b;
      default: out = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: EX branch resolution, BHT update, redirect/flush sequencing, perf counters
module branch_resolve_ctrl
  import rv32i_types::*;
#(
  parameter int BHT_IDX_W = 6,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  rv32i_word        id_pc,
  output logic             id_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_is_br,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  branch_funct3_t   ex_funct3,
  input  rv32i_word        ex_rs1,
  input  rv32i_word        ex_rs2,
  input  rv32i_word        ex_pc,
  input  rv32i_word        ex_imm,
  input  logic             ex_pred_taken,
  input  rv32i_word        ex_pred_target,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output rv32i_word        redirect_pc,
  output logic             flush,
  output logic             misalign_trap,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);
  br_ctrl_state_t   state_q, state_d;
  rv32i_word        redirect_pc_q, redirect_pc_d, target;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;
  logic             cmp_out, taken, resolve, misalign, mispred, redirect;
  bht_cnt_t         id_cnt;
  cmp u_cmp (.a(ex_rs1), .b(ex_rs2), .funct3(ex_funct3), .out(cmp_out));
  bht #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (id_pc[BHT_IDX_W+1:2]),
    .rd_cnt  (id_cnt),
    .wr_en   (resolve & ex_is_br & ~misalign),
    .wr_idx  (ex_pc[BHT_IDX_W+1:2]),
    .wr_taken(taken)
  );
  assign taken    = ex_is_br ? cmp_out : 1'b1;
  assign target   = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~32'h1) : ex_pc + ex_imm;
  assign resolve  = (state_q == IDLE) & ex_valid & ~ex_stall & (ex_is_br | ex_is_jal | ex_is_jalr);
  assign misalign = taken & (|target[1:0]);
  assign mispred  = (taken != ex_pred_taken) | (taken & (target != ex_pred_target));
  assign redirect = resolve & mispred & ~misalign;
  always_comb begin
    state_d       = state_q == REDIR ? (redirect_ready ? IDLE : REDIR) : (redirect ? REDIR : IDLE);
    redirect_pc_d = redirect ? (taken ? target : ex_pc + 32'd4) : redirect_pc_q;
    misalign_d    = resolve & misalign;
    br_cnt_d      = br_cnt_q + CNT_W'(resolve);
    mp_cnt_d      = mp_cnt_q + CNT_W'(redirect);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
      misalign_q    <= 1'b0;
      br_cnt_q      <= '0;
      mp_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      misalign_q    <= misalign_d;
      br_cnt_q      <= br_cnt_d;
      mp_cnt_q      <= mp_cnt_d;
    end
  end
  assign id_pred_taken  = id_cnt[1];
  assign redirect_valid = state_q == REDIR;
  assign flush          = state_q == REDIR;
  assign redirect_pc    = redirect_pc_q;
  assign misalign_trap  = misalign_q;
  assign br_count       = br_cnt_q;
  assign mp_count       = mp_cnt_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed + randomized check against a behavioural branch model
module tb_branch_resolve_ctrl;
  import rv32i_types::*;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] id_pc, ex_rs1, ex_rs2, ex_pc, ex_imm, ex_pred_target, redirect_pc, br_count, mp_count;
  logic id_pred_taken, ex_valid, ex_stall, ex_is_br, ex_is_jal, ex_is_jalr, ex_pred_taken;
  logic redirect_valid, redirect_ready, flush, misalign_trap;
  branch_funct3_t ex_funct3;
  int tests = 0, fails = 0;
  bit m_redir, m_trap;
  logic [31:0] m_rpc, m_br, m_mp;
  int m_bht [64];

  always #5 clk = ~clk;

  branch_resolve_ctrl dut (
    .clk(clk), .rst(rst), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_br(ex_is_br), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .flush(flush), .misalign_trap(misalign_trap), .br_count(br_count), .mp_count(mp_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit br_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] calc_target(input bit jalr, input logic [31:0] rs1,
                                              input logic [31:0] pc, input logic [31:0] imm);
    return jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : pc + imm;
  endfunction

  task automatic model_reset();
    m_redir = 0; m_trap = 0; m_rpc = 0; m_br = 0; m_mp = 0;
    foreach (m_bht[i]) m_bht[i] = 1;
  endtask

  task automatic model_step();
    bit tk;
    logic [31:0] tg;
    int idx;
    m_trap = 0;
    if (m_redir) begin
      if (redirect_ready) m_redir = 0;
    end else if (ex_valid && !ex_stall && (ex_is_br || ex_is_jal || ex_is_jalr)) begin
      m_br++;
      tk = ex_is_br ? br_taken(ex_funct3, ex_rs1, ex_rs2) : 1'b1;
      tg = calc_target(ex_is_jalr, ex_rs1, ex_pc, ex_imm);
      if (tk && tg[1:0] != 2'b00) m_trap = 1;
      else begin
        idx = int'(ex_pc[7:2]);
        if (ex_is_br) m_bht[idx] = tk ? (m_bht[idx] == 3 ? 3 : m_bht[idx] + 1)
                                       : (m_bht[idx] == 0 ? 0 : m_bht[idx] - 1);
        if (tk != ex_pred_taken || (tk && tg != ex_pred_target)) begin
          m_mp++;
          m_rpc = tk ? tg : ex_pc + 32'd4;
          m_redir = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_redir});
    check("flush", {31'b0, flush}, {31'b0, m_redir});
    check("redirect_pc", redirect_pc, m_rpc);
    check("misalign_trap", {31'b0, misalign_trap}, {31'b0, m_trap});
    check("br_count", br_count, m_br);
    check("mp_count", mp_count, m_mp);
  endtask

  task automatic cycle();
    int idx;
    #1;
    idx = int'(id_pc[7:2]);
    check("id_pred_taken", {31'b0, id_pred_taken}, {31'b0, m_bht[idx] >= 2});
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_ex(input bit v, input bit b, input bit j, input bit jr, input logic [2:0] f,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] pc,
                        input logic [31:0] imm, input bit pt, input logic [31:0] ptg);
    ex_valid = v; ex_is_br = b; ex_is_jal = j; ex_is_jalr = jr; ex_funct3 = branch_funct3_t'(f);
    ex_rs1 = r1; ex_rs2 = r2; ex_pc = pc; ex_imm = imm; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  initial begin
    rst = 1'b0; id_pc = 0; ex_stall = 0; redirect_ready = 1;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1'b1;
    // BEQ equal, predicted not-taken -> redirect to 0x120
    set_ex(1, 1, 0, 0, 3'd0, 5, 5, 32'h100, 32'h20, 0, 0);
    redirect_ready = 0;
    cycle();
    check("beq_rpc", redirect_pc, 32'h120);
    redirect_ready = 1;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    // BLT -1 < 1 correctly predicted taken
    set_ex(1, 1, 0, 0, 3'd4, 32'hFFFF_FFFF, 1, 32'h100, 32'h40, 1, 32'h140);
    cycle();
    check("blt_no_redir", {31'b0, redirect_valid}, 32'd0);
    check("blt_mp", mp_count, 32'd1);
    // JALR to 0x212 traps
    set_ex(1, 0, 0, 1, 0, 32'h203, 0, 32'h180, 32'h10, 0, 0);
    cycle();
    check("jalr_trap", {31'b0, misalign_trap}, 32'd1);
    set_ex(1, 0, 0, 1, 0, 32'h200, 0, 32'h180, 32'h10, 0, 0);
    redirect_ready = 0;
    cycle();
    check("jalr_rpc", redirect_pc, 32'h210);
    check("trap_drop", {31'b0, misalign_trap}, 32'd0);
    // held redirect ignores wrong-path branches
    set_ex(1, 1, 0, 0, 3'd1, 1, 2, 32'h40, 32'h8, 0, 0);
    repeat (3) cycle();
    redirect_ready = 1;
    cycle();
    check("held_br_count", br_count, 32'd4);
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    // saturation on index 5
    id_pc = 32'h114;
    for (int i = 0; i < 4; i++) begin
      set_ex(1, 1, 0, 0, 3'd0, 7, 7, 32'h114, 32'h8, 1, 32'h11C);
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      set_ex(1, 1, 0, 0, 3'd0, 7, 8, 32'h114, 32'h8, 0, 0);
      cycle();
    end
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    // stalled branch is not resolved
    ex_stall = 1;
    set_ex(1, 1, 0, 0, 3'd0, 1, 1, 32'h114, 32'h8, 0, 0);
    repeat (2) cycle();
    ex_stall = 0;
    // async reset in REDIR
    set_ex(1, 0, 1, 0, 0, 0, 0, 32'h114, 32'h20, 0, 0);
    redirect_ready = 0;
    cycle();
    #2 rst = 1'b0;
    #1 model_reset();
    check_outputs();
    check("rst_pred", {31'b0, id_pred_taken}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    redirect_ready = 1;
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] vals [4];
      int kind;
      bit pt;
      logic [31:0] pc, imm, r1, tg;
      vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd5};
      kind = int'($urandom_range(0, 3));
      pc = 32'($urandom_range(0, 127)) << 2;
      imm = (32'($urandom_range(0, 15)) << 2) - 32'd32 + ($urandom_range(0, 7) == 0 ? 32'd2 : 32'd0);
      r1 = $urandom_range(0, 1) ? vals[$urandom_range(0, 3)] : 32'($urandom_range(0, 255));
      pt = 1'($urandom_range(0, 1));
      tg = calc_target(kind == 3, r1, pc, imm);
      set_ex($urandom_range(0, 5) != 0, kind <= 1, kind == 2, kind == 3, 3'($urandom_range(0, 7)),
             r1, vals[$urandom_range(0, 3)], pc, imm, pt, $urandom_range(0, 2) != 0 ? tg : $urandom);
      ex_stall = $urandom_range(0, 5) == 0;
      redirect_ready = $urandom_range(0, 2) != 0;
      id_pc = 32'($urandom_range(0, 127)) << 2;
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
